// File: rtl/zynq_axi_pkg.sv
// Shared AXI3 constants and controller state type for the memory-to-AXI3 burst master.
package zynq_axi_pkg;

  localparam int axi3_len_w = 4;
  localparam int axi3_id_w  = 6;

  localparam logic [1:0] burst_incr = 2'b01;
  localparam logic [1:0] resp_okay  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WDATA,
    WRESP,
    RADDR,
    RDATA
  } state_e;

endpackage

// File: rtl/zynq_axi_beat_counter.sv
// Beat counter shared by the W and R paths; last_o flags the final beat of a burst.
module zynq_axi_beat_counter #(
  parameter int burst_len_p = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int cnt_w = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

  logic [cnt_w-1:0] count;

  assign last_o = (count == cnt_w'(burst_len_p - 1));

  // Wraps to zero on the final beat so a burst of length 1 is always "last".
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      count <= '0;
    end else if (inc_i) begin
      count <= last_o ? '0 : count + cnt_w'(1);
    end
  end

endmodule

// File: rtl/zynq_mem_to_axi3_master.sv
// Turns a valid/ready block request stream into single-outstanding AXI3 INCR bursts,
// passing write and read beats straight through between the accelerator and m00_axi.
module zynq_mem_to_axi3_master
  import zynq_axi_pkg::*;
#(
  parameter int          addr_width_p = 32,
  parameter int          data_width_p = 32,
  parameter int          burst_len_p  = 8,
  parameter int unsigned axi_id_p     = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        req_v_i,
  input  logic                        req_w_i,
  input  logic [addr_width_p-1:0]     req_addr_i,
  output logic                        req_ready_o,
  input  logic                        wdata_v_i,
  input  logic [data_width_p-1:0]     wdata_i,
  output logic                        wdata_ready_o,
  output logic                        rdata_v_o,
  output logic [data_width_p-1:0]     rdata_o,
  input  logic                        rdata_ready_i,
  output logic                        wr_done_o,
  output logic                        error_o,
  output logic [addr_width_p-1:0]     m00_axi_awaddr,
  output logic [axi3_id_w-1:0]        m00_axi_awid,
  output logic [axi3_len_w-1:0]       m00_axi_awlen,
  output logic [2:0]                  m00_axi_awsize,
  output logic [1:0]                  m00_axi_awburst,
  output logic                        m00_axi_awvalid,
  input  logic                        m00_axi_awready,
  output logic [data_width_p-1:0]     m00_axi_wdata,
  output logic [data_width_p/8-1:0]   m00_axi_wstrb,
  output logic [axi3_id_w-1:0]        m00_axi_wid,
  output logic                        m00_axi_wlast,
  output logic                        m00_axi_wvalid,
  input  logic                        m00_axi_wready,
  input  logic [axi3_id_w-1:0]        m00_axi_bid,
  input  logic [1:0]                  m00_axi_bresp,
  input  logic                        m00_axi_bvalid,
  output logic                        m00_axi_bready,
  output logic [addr_width_p-1:0]     m00_axi_araddr,
  output logic [axi3_id_w-1:0]        m00_axi_arid,
  output logic [axi3_len_w-1:0]       m00_axi_arlen,
  output logic [2:0]                  m00_axi_arsize,
  output logic [1:0]                  m00_axi_arburst,
  output logic                        m00_axi_arvalid,
  input  logic                        m00_axi_arready,
  input  logic [data_width_p-1:0]     m00_axi_rdata,
  input  logic [axi3_id_w-1:0]        m00_axi_rid,
  input  logic [1:0]                  m00_axi_rresp,
  input  logic                        m00_axi_rlast,
  input  logic                        m00_axi_rvalid,
  output logic                        m00_axi_rready
);

  localparam int beat_bytes = data_width_p / 8;
  localparam int off_bits   = $clog2(burst_len_p * beat_bytes);
  localparam logic [addr_width_p-1:0] addr_mask = {addr_width_p{1'b1}} << off_bits;
  localparam logic [axi3_id_w-1:0]    id_c      = axi3_id_w'(axi_id_p);
  localparam logic [axi3_len_w-1:0]   len_c     = axi3_len_w'(burst_len_p - 1);
  localparam logic [2:0]              size_c    = 3'($clog2(beat_bytes));

  state_e                  state;
  logic [addr_width_p-1:0] addr;
  logic                    error;
  logic                    last;
  logic                    run;
  logic                    accept;
  logic                    w_hs;
  logic                    r_hs;

  // Outputs are forced low while reset is held, not just after it is sampled.
  assign run    = ~reset_i;
  assign accept = req_v_i & req_ready_o;
  assign w_hs   = m00_axi_wvalid & m00_axi_wready;
  assign r_hs   = m00_axi_rvalid & m00_axi_rready;

  assign req_ready_o     = run & (state == IDLE);
  assign m00_axi_awvalid = run & (state == WADDR);
  assign m00_axi_arvalid = run & (state == RADDR);
  assign m00_axi_wvalid  = run & (state == WDATA) & wdata_v_i;
  assign wdata_ready_o   = run & (state == WDATA) & m00_axi_wready;
  assign m00_axi_wlast   = (state == WDATA) & last;
  assign m00_axi_bready  = run & (state == WRESP);
  assign wr_done_o       = run & (state == WRESP) & m00_axi_bvalid;
  assign rdata_v_o       = run & (state == RDATA) & m00_axi_rvalid;
  assign m00_axi_rready  = run & (state == RDATA) & rdata_ready_i;
  assign rdata_o         = m00_axi_rdata;
  assign m00_axi_wdata   = wdata_i;
  assign error_o         = error;

  assign m00_axi_awaddr  = addr;
  assign m00_axi_araddr  = addr;
  assign m00_axi_awid    = id_c;
  assign m00_axi_wid     = id_c;
  assign m00_axi_arid    = id_c;
  assign m00_axi_awlen   = len_c;
  assign m00_axi_arlen   = len_c;
  assign m00_axi_awsize  = size_c;
  assign m00_axi_arsize  = size_c;
  assign m00_axi_awburst = burst_incr;
  assign m00_axi_arburst = burst_incr;
  assign m00_axi_wstrb   = '1;

  zynq_axi_beat_counter #(.burst_len_p(burst_len_p)) u_beat_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (accept),
    .inc_i  (w_hs | r_hs),
    .last_o (last)
  );

  // Address is burst-aligned on accept; misaligned low bits are simply dropped.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr <= req_addr_i & addr_mask;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (req_v_i) state <= req_w_i ? WADDR : RADDR;
        WADDR: if (m00_axi_awready) state <= WDATA;
        WDATA: if (w_hs && last) state <= WRESP;
        WRESP: begin
          if (m00_axi_bvalid) begin
            state <= IDLE;
            if (m00_axi_bresp != resp_okay || m00_axi_bid != id_c) error <= 1'b1;
          end
        end
        RADDR: if (m00_axi_arready) state <= RDATA;
        RDATA: begin
          if (r_hs) begin
            if (last) state <= IDLE;
            if (m00_axi_rresp != resp_okay || m00_axi_rlast != last || m00_axi_rid != id_c)
              error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zynq_mem_to_axi3_master.sv
// Scoreboard bench for zynq_mem_to_axi3_master with a small AXI3 memory model.
module tb_zynq_mem_to_axi3_master;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_v_i, req_w_i;
  logic [31:0] req_addr_i;
  logic        req_ready_o;
  logic        wdata_v_i;
  logic [31:0] wdata_i;
  logic        wdata_ready_o;
  logic        rdata_v_o;
  logic [31:0] rdata_o;
  logic        rdata_ready_i;
  logic        wr_done_o, error_o;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [5:0]  awid, wid, arid, bid, rid;
  logic [3:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  zynq_mem_to_axi3_master dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_w_i(req_w_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .wdata_v_i(wdata_v_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
    .rdata_v_o(rdata_v_o), .rdata_o(rdata_o), .rdata_ready_i(rdata_ready_i),
    .wr_done_o(wr_done_o), .error_o(error_o),
    .m00_axi_awaddr(awaddr), .m00_axi_awid(awid), .m00_axi_awlen(awlen),
    .m00_axi_awsize(awsize), .m00_axi_awburst(awburst), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wid(wid), .m00_axi_wlast(wlast),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arid(arid), .m00_axi_arlen(arlen),
    .m00_axi_arsize(arsize), .m00_axi_arburst(arburst), .m00_axi_arvalid(arvalid),
    .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rid(rid), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:4095];
  logic [11:0] wr_ptr, rd_ptr;
  logic [3:0]  rd_cnt;
  logic [1:0]  force_bresp;

  assign wready = 1'b1;
  assign bid    = 6'd0;
  assign rid    = 6'd0;
  assign rresp  = 2'b00;
  assign bresp  = force_bresp;
  assign rdata  = mem[rd_ptr];
  assign rlast  = (rd_cnt == 4'd7);

  always @(posedge clk) begin
    if (reset_i) begin
      awready <= 1'b0; arready <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      rd_cnt  <= 4'd0;
    end else begin
      awready <= awvalid && !awready;
      arready <= arvalid && !arready;
      if (awvalid && awready) wr_ptr <= awaddr[13:2];
      if (wvalid && wready) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + 12'd1;
        if (wlast) bvalid <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rd_ptr <= araddr[13:2]; rd_cnt <= 4'd0; rvalid <= 1'b1;
      end
      if (rvalid && rready) begin
        rd_ptr <= rd_ptr + 12'd1;
        rd_cnt <= rd_cnt + 4'd1;
        if (rd_cnt == 4'd7) rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;
  int w_hs_cnt = 0;
  int r_hs_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_aw[$], exp_ar[$], exp_r[$];
  logic [32:0] exp_w[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_i) begin
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else check("awaddr", 64'(awaddr), 64'(exp_aw.pop_front()));
        check("awlen_size_burst_id", {awlen, awsize, awburst, awid, wid}, {4'd7, 3'd2, 2'b01, 6'd0, 6'd0});
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
        else check("araddr", 64'(araddr), 64'(exp_ar.pop_front()));
        check("arlen_size_burst_id", {arlen, arsize, arburst, arid}, {4'd7, 3'd2, 2'b01, 6'd0});
      end
      if (wvalid && wready) begin
        w_hs_cnt++;
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else check("wlast_wdata", {wlast, wdata}, 64'(exp_w.pop_front()));
        check("wstrb", 64'(wstrb), 64'hF);
      end
      if (rdata_v_o && rdata_ready_i) begin
        r_hs_cnt++;
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else check("rdata", 64'(rdata_o), 64'(exp_r.pop_front()));
      end
      if (wr_done_o) done_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_req(input logic w, input logic [31:0] a);
    int t = 0;
    while (!req_ready_o && t < 200) begin tick(); t++; end
    check("req_ready_wait", 64'(req_ready_o), 1);
    req_v_i = 1'b1; req_w_i = w; req_addr_i = a;
    tick();
    req_v_i = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] base, input int stall_after);
    int t;
    int hs0;
    for (int i = 0; i < 8; i++) exp_w.push_back({(i == 7), base + 32'(i)});
    for (int i = 0; i < 8; i++) begin
      if (i == stall_after) begin
        wdata_v_i = 1'b0;
        hs0 = w_hs_cnt;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (k % 5 == 0) check("wvalid_stall", 64'(wvalid), 0);
          tick();
        end
        check("stall_counter_hold", 64'(w_hs_cnt), 64'(hs0));
      end
      wdata_v_i = 1'b1; wdata_i = base + 32'(i);
      t = 0;
      while (!wdata_ready_o && t < 200) begin tick(); t++; end
      if (t >= 200) check("w_timeout", 1, 0);
      tick();
    end
    wdata_v_i = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int t = 0;
    while (done_cnt == prev && t < 200) begin tick(); t++; end
    repeat (3) tick();
    check("wr_done_once", 64'(done_cnt), 64'(prev + 1));
  endtask

  task automatic wait_r_empty(input string nm);
    int t = 0;
    while (exp_r.size() != 0 && t < 300) begin tick(); t++; end
    check(nm, 64'(exp_r.size()), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] al, input logic [31:0] base,
                          input int stall_after);
    int d0 = done_cnt;
    int h0 = w_hs_cnt;
    exp_aw.push_back(al);
    issue_req(1'b1, a);
    send_w(base, stall_after);
    wait_done(d0);
    check("w_hs_count", 64'(w_hs_cnt - h0), 8);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] al, input logic [31:0] base);
    exp_ar.push_back(al);
    for (int i = 0; i < 8; i++) exp_r.push_back(base + 32'(i));
    issue_req(1'b0, a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int t;
    reset_i = 1'b1; req_v_i = 1'b0; req_w_i = 1'b0; req_addr_i = '0;
    wdata_v_i = 1'b0; wdata_i = '0; rdata_ready_i = 1'b1; force_bresp = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {req_ready_o, awvalid, arvalid, wvalid, bready, rready, wr_done_o, error_o}, 0);
    tick();
    reset_i = 1'b0;
    tick();
    check("idle_ready", 64'(req_ready_o), 1);

    // Aligned write then read-back.
    do_write(32'h1000, 32'h1000, 32'hA0, 99);
    do_read(32'h1000, 32'h1000, 32'hA0);
    wait_r_empty("readback_A");

    // Misaligned request is truncated to the burst boundary.
    do_write(32'h101C, 32'h1000, 32'hB0, 99);
    do_read(32'h101C, 32'h1000, 32'hB0);
    wait_r_empty("readback_B");
    check("error_clean", 64'(error_o), 0);

    // Read under toggling consumer backpressure.
    r0 = r_hs_cnt;
    do_read(32'h1000, 32'h1000, 32'hB0);
    t = 0;
    while (exp_r.size() != 0 && t < 300) begin
      rdata_ready_i = ~rdata_ready_i;
      @(negedge clk);
      if (rvalid && (t % 3 == 0)) check("rready_mirror", 64'(rready), 64'(rdata_ready_i));
      tick();
      t++;
    end
    rdata_ready_i = 1'b1;
    check("toggle_beats", 64'(r_hs_cnt - r0), 8);
    tick();
    check("idle_after_toggle", 64'(req_ready_o), 1);

    // Write with a 20-cycle producer stall after beat 3.
    do_write(32'h1800, 32'h1800, 32'hE0, 4);

    // Error response on B.
    force_bresp = 2'b10;
    do_write(32'h3000, 32'h3000, 32'hD0, 99);
    force_bresp = 2'b00;
    check("error_after_bresp", 64'(error_o), 1);
    do_read(32'h3000, 32'h3000, 32'hD0);
    wait_r_empty("read_after_error");
    check("error_sticky", 64'(error_o), 1);

    // Reset in the middle of a read burst.
    r0 = r_hs_cnt;
    do_read(32'h1000, 32'h1000, 32'hB0);
    t = 0;
    while (r_hs_cnt < r0 + 3 && t < 200) begin tick(); t++; end
    reset_i = 1'b1;
    tick();
    check("mid_reset_ready_rready", {req_ready_o, rready}, 0);
    check("mid_reset_beats", 64'(r_hs_cnt - r0), 3);
    exp_r.delete();
    reset_i = 1'b0;
    tick();
    check("post_reset_idle_err", {req_ready_o, error_o}, 2'b10);

    do_write(32'h2000, 32'h2000, 32'hC0, 99);
    do_read(32'h2000, 32'h2000, 32'hC0);
    wait_r_empty("readback_C");

    check("queues_drained", 64'(exp_aw.size() + exp_ar.size() + exp_w.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
